// File: rtl/raycast_wb_slave_regs_pkg.sv
// Register-map definitions shared by the raycaster Wishbone register file.
// Holds word indices, CTRL/STATUS bit positions and a big-endian byte
// insertion helper. The block is decoded at base 0x9C000000; only the
// low five address bits reach this slave.
package raycast_wb_slave_regs_pkg;

    // Aligned 32-bit word index, taken from byte address bits [4:2]
    typedef enum logic [2:0] {
        W_CTRL_STATUS = 3'd0,
        W_RAY_ADR     = 3'd1,
        W_RAY_COUNT   = 3'd2,
        W_OCT_ADR     = 3'd3,
        W_FB_ADR      = 3'd4,
        W_PERF_CYC    = 3'd5,
        W_RSVD6       = 3'd6,
        W_RSVD7       = 3'd7
    } word_e;

    // Byte positions of CTRL and STATUS inside word 0 (lowest offset = MS byte)
    localparam logic [1:0] POS_CTRL   = 2'd0;
    localparam logic [1:0] POS_STATUS = 2'd1;

    localparam int CTRL_START_BIT     = 0;
    localparam int CTRL_IRQ_EN_BIT    = 1;
    localparam int STATUS_DONE_BIT    = 0;
    localparam int STATUS_BUSY_BIT    = 1;
    localparam int STATUS_OVERRUN_BIT = 2;

    // Replace one byte of a big-endian word; pos 0 is bits [31:24]
    function automatic logic [31:0] put_be_byte(input logic [31:0] word,
                                                input logic [1:0]  pos,
                                                input logic [7:0]  value);
        logic [31:0] r;
        r = word;
        case (pos)
            2'd0:    r[31:24] = value;
            2'd1:    r[23:16] = value;
            2'd2:    r[15:8]  = value;
            default: r[7:0]   = value;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/raycast_wb_byte_wr.sv
// Write-lane selector: picks the single byte lane named by a one-hot
// Wishbone select and flags any select that is zero or multi-hot.
module raycast_wb_byte_wr (
    input  logic [31:0] dat,
    input  logic [3:0]  sel,
    output logic [7:0]  lane_byte,
    output logic        sel_err
);

    // One-hot lane mux; anything else is an error and yields no byte
    always_comb begin
        lane_byte = 8'h00;
        sel_err   = 1'b0;
        case (sel)
            4'b1000: lane_byte = dat[31:24];
            4'b0100: lane_byte = dat[23:16];
            4'b0010: lane_byte = dat[15:8];
            4'b0001: lane_byte = dat[7:0];
            default: sel_err   = 1'b1;
        endcase
    end

endmodule

// File: rtl/raycast_wb_slave_regs.sv
// Wishbone B3 classic byte-register file for the raycaster core: config
// addresses, start/done handshake with the core and a level interrupt.
// Optional feature macro RAYC_PERF_CNT_EN adds the read-only PERF_CYC
// busy-cycle counter at byte offsets 0x14-0x17.
module raycast_wb_slave_regs
    import raycast_wb_slave_regs_pkg::*;
#(
    parameter logic [31:0] RAY_COUNT_RST = 32'd0,
    parameter logic [31:0] BUF_ADR_RST   = 32'd0
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic [2:0]  wb_cti_i,
    input  logic [1:0]  wb_bte_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o,
    output logic        start_o,
    input  logic        done_i,
    output logic [31:0] ray_adr_o,
    output logic [31:0] ray_count_o,
    output logic [31:0] oct_adr_o,
    output logic [31:0] fb_adr_o,
    output logic        irq_o
);

    logic [7:0]  wr_byte;
    logic        sel_err;
    logic        req, wr_en, rd_req;
    word_e       wsel;
    logic [1:0]  bpos;
    logic        ctrl_wr, status_wr, start_wr, start_ok, start_ovr;
    logic        irq_en, busy, done, overrun;
    logic        done_nxt, irq_en_nxt;
    logic [31:0] rd_word;
    logic        unused;

    raycast_wb_byte_wr u_byte_wr (
        .dat       (wb_dat_i),
        .sel       (wb_sel_i),
        .lane_byte (wr_byte),
        .sel_err   (sel_err)
    );

    // A new request is one not already answered in the current cycle
    assign req    = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
    assign wr_en  = req & wb_we_i & ~sel_err;
    assign rd_req = req & ~wb_we_i;
    assign wsel   = word_e'(wb_adr_i[4:2]);
    assign bpos   = wb_adr_i[1:0];

    assign ctrl_wr   = wr_en & (wsel == W_CTRL_STATUS) & (bpos == POS_CTRL);
    assign status_wr = wr_en & (wsel == W_CTRL_STATUS) & (bpos == POS_STATUS);
    assign start_wr  = ctrl_wr & wr_byte[CTRL_START_BIT];
    // A done arriving in the same cycle frees the core, so the start is taken
    assign start_ok  = start_wr & (~busy | done_i);
    assign start_ovr = start_wr & busy & ~done_i;

    assign wb_rty_o = 1'b0;
    assign unused   = ^{wb_adr_i[31:5], wb_cti_i, wb_bte_i};

`ifdef RAYC_PERF_CNT_EN
    logic [31:0] perf_cyc;

    // Busy-cycle counter: restarts with each accepted start, saturates
    always_ff @(posedge wb_clk) begin
        if (wb_rst)
            perf_cyc <= 32'd0;
        else if (start_ok)
            perf_cyc <= 32'd0;
        else if (busy && perf_cyc != 32'hFFFF_FFFF)
            perf_cyc <= perf_cyc + 32'd1;
    end
`endif

    // Next-state for done (done_i beats W1C) and irq_en, shared with irq_o
    always_comb begin
        done_nxt = done;
        if (done_i)
            done_nxt = 1'b1;
        else if (status_wr && wr_byte[STATUS_DONE_BIT])
            done_nxt = 1'b0;
        irq_en_nxt = ctrl_wr ? wr_byte[CTRL_IRQ_EN_BIT] : irq_en;
    end

    // Read mux: aligned word, big-endian packed; start always reads 0
    always_comb begin
        rd_word = 32'h0;
        case (wsel)
            W_CTRL_STATUS: rd_word = {6'b0, irq_en, 1'b0,
                                      5'b0, overrun, busy, done, 16'h0};
            W_RAY_ADR:     rd_word = ray_adr_o;
            W_RAY_COUNT:   rd_word = ray_count_o;
            W_OCT_ADR:     rd_word = oct_adr_o;
            W_FB_ADR:      rd_word = fb_adr_o;
`ifdef RAYC_PERF_CNT_EN
            W_PERF_CYC:    rd_word = perf_cyc;
`endif
            default:       rd_word = 32'h0;
        endcase
    end

    // Bus response: one-cycle ack or err, read data only in the ack cycle
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= 32'h0;
        end else begin
            wb_ack_o <= req & ~(wb_we_i & sel_err);
            wb_err_o <= req & wb_we_i & sel_err;
            wb_dat_o <= rd_req ? rd_word : 32'h0;
        end
    end

    // Control/status: start pulse, busy tracking, sticky flags, interrupt
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            start_o <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            overrun <= 1'b0;
            irq_en  <= 1'b0;
            irq_o   <= 1'b0;
        end else begin
            start_o <= start_ok;
            if (start_ok)
                busy <= 1'b1;
            else if (done_i)
                busy <= 1'b0;
            if (start_ovr)
                overrun <= 1'b1;
            else if (status_wr && wr_byte[STATUS_OVERRUN_BIT])
                overrun <= 1'b0;
            done   <= done_nxt;
            irq_en <= irq_en_nxt;
            irq_o  <= done_nxt & irq_en_nxt;
        end
    end

    // Config fields: one big-endian byte per accepted write
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            ray_adr_o   <= BUF_ADR_RST;
            ray_count_o <= RAY_COUNT_RST;
            oct_adr_o   <= BUF_ADR_RST;
            fb_adr_o    <= BUF_ADR_RST;
        end else if (wr_en) begin
            case (wsel)
                W_RAY_ADR:   ray_adr_o   <= put_be_byte(ray_adr_o, bpos, wr_byte);
                W_RAY_COUNT: ray_count_o <= put_be_byte(ray_count_o, bpos, wr_byte);
                W_OCT_ADR:   oct_adr_o   <= put_be_byte(oct_adr_o, bpos, wr_byte);
                W_FB_ADR:    fb_adr_o    <= put_be_byte(fb_adr_o, bpos, wr_byte);
                default:     ;
            endcase
        end
    end

endmodule
